// File: rtl/cfg_mgmt_arb_pkg.sv
// rtl/cfg_mgmt_arb_pkg.sv - shared types and constants for cfg_mgmt_arbiter
//
// Purpose: FSM state encoding, cfg_mgmt field widths and the read data
// returned for an access that the watchdog aborts.
package cfg_mgmt_arb_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_priority_arbiter.sv
// rtl/rr_priority_arbiter.sv - combinational round-robin grant selection
//
// Purpose: picks the first asserted request at or after ptr, wrapping.
// Ports:
//   req       in   NUM_REQ  request vector
//   ptr       in   IDX_W    highest-priority index this round
//   grant_oh  out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx out  IDX_W    encoded grant index
//   any_req   out  1        at least one request asserted
module rr_priority_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // ptr + off folded back into 0..NUM_REQ-1 (NUM_REQ need not be a power of 2)
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    grant_idx = '0;
    any_req   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_req && req[wrap_idx(ptr, k)]) begin
        any_req   = 1'b1;
        grant_idx = wrap_idx(ptr, k);
      end
    end
    grant_oh = any_req ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cfg_mgmt_arbiter.sv
// rtl/cfg_mgmt_arbiter.sv - round-robin sharing of the core cfg_mgmt port
//
// Purpose: serialises config accesses from NUM_REQ requesters onto one
// cfg_mgmt port, steers completion back, aborts hung accesses.
// Ports:
//   user_clk, user_reset_n           clock, sync active-low reset
//   req_valid/write/type1            per-requester request and kind
//   req_addr/wdata/be                packed per-requester fields
//   rsp_valid/rdata/timeout          one-cycle completion to the granted requester
//   cfg_mgmt_*                       core configuration management port
module cfg_mgmt_arbiter
  import cfg_mgmt_arb_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        user_clk,
  input  logic                        user_reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ-1:0]          req_type1,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ*BE_W-1:0]     req_be,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic                        rsp_timeout,
  output logic [ADDR_W-1:0]           cfg_mgmt_addr,
  output logic [DATA_W-1:0]           cfg_mgmt_write_data,
  output logic [BE_W-1:0]             cfg_mgmt_byte_enable,
  output logic                        cfg_mgmt_write,
  output logic                        cfg_mgmt_read,
  output logic                        cfg_mgmt_type1_cfg_reg_access,
  input  logic [DATA_W-1:0]           cfg_mgmt_read_data,
  input  logic                        cfg_mgmt_read_write_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic              write_q, write_d;
  logic              type1_q, type1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;

  logic [NUM_REQ-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_priority_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_ff @(posedge user_clk) begin
    if (!user_reset_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      write_q   <= 1'b0;
      type1_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      write_q   <= write_d;
      type1_q   <= type1_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
      wdog_q    <= wdog_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    write_d   = write_q;
    type1_d   = type1_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    wdog_d    = wdog_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          // Latch the request so the requester may drop valid mid-access.
          grant_d  = arb_idx;
          write_d  = req_write[arb_idx];
          type1_d  = req_type1[arb_idx];
          addr_d   = req_addr[arb_idx*ADDR_W +: ADDR_W];
          wdata_d  = req_wdata[arb_idx*DATA_W +: DATA_W];
          be_d     = req_be[arb_idx*BE_W +: BE_W];
          rr_ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
          wdog_d   = '0;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // done is checked first so it wins over a coincident expiry
        if (cfg_mgmt_read_write_done) begin
          rdata_d   = write_q ? '0 : cfg_mgmt_read_data;
          timeout_d = 1'b0;
          state_d   = RESP;
        end else if (wdog_q == WD_LAST) begin
          rdata_d   = TIMEOUT_RDATA;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      RESP:    state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_mgmt_read                 = (state_q == ISSUE) && !write_q;
    cfg_mgmt_write                = (state_q == ISSUE) && write_q;
    cfg_mgmt_type1_cfg_reg_access = (state_q == ISSUE) && type1_q;
    cfg_mgmt_addr                 = (state_q == ISSUE) ? addr_q  : '0;
    cfg_mgmt_write_data           = (state_q == ISSUE) ? wdata_q : '0;
    cfg_mgmt_byte_enable          = (state_q == ISSUE) ? be_q    : '0;
    rsp_valid                     = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    rsp_rdata                     = (state_q == RESP) ? rdata_q : '0;
    rsp_timeout                   = (state_q == RESP) && timeout_q;
  end

endmodule

// File: tb/tb_cfg_mgmt_arbiter.sv
// tb/tb_cfg_mgmt_arbiter.sv - self-checking bench for cfg_mgmt_arbiter
module tb_cfg_mgmt_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic          user_clk = 1'b0;
  logic          user_reset_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_write = '0;
  logic [N-1:0]  req_type1 = '0;
  logic [N*10-1:0] req_addr = '0;
  logic [N*32-1:0] req_wdata = '0;
  logic [N*4-1:0]  req_be = '0;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_timeout;
  logic [9:0]    cfg_mgmt_addr;
  logic [31:0]   cfg_mgmt_write_data;
  logic [3:0]    cfg_mgmt_byte_enable;
  logic          cfg_mgmt_write;
  logic          cfg_mgmt_read;
  logic          cfg_mgmt_type1_cfg_reg_access;
  logic [31:0]   cfg_mgmt_read_data = '0;
  logic          cfg_mgmt_read_write_done = 1'b0;

  cfg_mgmt_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .user_clk                      (user_clk),
    .user_reset_n                  (user_reset_n),
    .req_valid                     (req_valid),
    .req_write                     (req_write),
    .req_type1                     (req_type1),
    .req_addr                      (req_addr),
    .req_wdata                     (req_wdata),
    .req_be                        (req_be),
    .rsp_valid                     (rsp_valid),
    .rsp_rdata                     (rsp_rdata),
    .rsp_timeout                   (rsp_timeout),
    .cfg_mgmt_addr                 (cfg_mgmt_addr),
    .cfg_mgmt_write_data           (cfg_mgmt_write_data),
    .cfg_mgmt_byte_enable          (cfg_mgmt_byte_enable),
    .cfg_mgmt_write                (cfg_mgmt_write),
    .cfg_mgmt_read                 (cfg_mgmt_read),
    .cfg_mgmt_type1_cfg_reg_access (cfg_mgmt_type1_cfg_reg_access),
    .cfg_mgmt_read_data            (cfg_mgmt_read_data),
    .cfg_mgmt_read_write_done      (cfg_mgmt_read_write_done)
  );

  always #5 user_clk = ~user_clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- core responder ----------------
  bit          rand_mode = 0;
  int          dir_lat = 2;          // strobe cycles before done; -1 = never
  logic [31:0] dir_rdata = '0;
  int          rcnt = 0;
  int          cur_lat = 0;

  always @(posedge user_clk) begin
    #2;
    if (cfg_mgmt_read || cfg_mgmt_write) begin
      rcnt++;
      if (rcnt == 1) begin
        if (rand_mode) begin
          case ($urandom_range(0, 9))
            0:       cur_lat = -1;
            1:       cur_lat = TO;
            2:       cur_lat = TO - 1;
            default: cur_lat = int'($urandom_range(1, 6));
          endcase
        end else cur_lat = dir_lat;
      end
      cfg_mgmt_read_write_done = (rcnt == cur_lat);
      cfg_mgmt_read_data = rand_mode ? $urandom : dir_rdata;
    end else begin
      rcnt = 0;
      cfg_mgmt_read_write_done = rand_mode ? ($urandom_range(0, 7) == 0) : 1'b0;
      cfg_mgmt_read_data = rand_mode ? $urandom : 32'h0;
    end
  end

  // ---------------- behavioural model ----------------
  // An access occupies the port for m_age cycles; after it ends the response
  // appears one cycle later and the port is free for new grants two cycles
  // after that (response + turnaround).
  bit          m_init = 0;
  bit          m_busy = 0;
  int          m_after = 0;     // 1 = response cycle, 2 = turnaround cycle
  int          m_age = 0;
  int          m_ptr = 0;
  int          m_who = 0;
  bit          m_wr = 0, m_t1 = 0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_rdata = '0;
  bit          m_to = 0;

  always @(posedge user_clk) begin
    m_init = 1;
    if (!user_reset_n) begin
      m_busy = 0; m_after = 0; m_ptr = 0;
    end else if (m_busy) begin
      m_age++;
      if (cfg_mgmt_read_write_done) begin
        m_rdata = m_wr ? 32'h0 : cfg_mgmt_read_data; m_to = 0; m_busy = 0; m_after = 1;
      end else if (m_age == TO) begin
        m_rdata = 32'hFFFF_FFFF; m_to = 1; m_busy = 0; m_after = 1;
      end
    end else if (m_after != 0) begin
      m_after = (m_after == 2) ? 0 : m_after + 1;
    end else begin
      bit found;
      found = 0;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!found && req_valid[c]) begin
          found = 1; m_who = c;
        end
      end
      if (found) begin
        m_busy = 1; m_age = 0; m_ptr = (m_who + 1) % N;
        m_wr = req_write[m_who]; m_t1 = req_type1[m_who];
        m_addr = req_addr[m_who*10 +: 10]; m_wdata = req_wdata[m_who*32 +: 32];
        m_be = req_be[m_who*4 +: 4];
      end
    end
  end

  // ---------------- compare + monitor ----------------
  logic [3:0]  rsp_who_q[$];
  logic [31:0] rsp_data_q[$];
  logic        rsp_to_q[$];
  int          rsp_len_q[$];
  int          cur_len = 0;
  logic        cap_wr = 0;
  logic [9:0]  cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_be = '0;

  always @(negedge user_clk) begin
    if (m_init) begin
      chk("cfg_bus",
          {cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_type1_cfg_reg_access,
           cfg_mgmt_addr, cfg_mgmt_byte_enable, cfg_mgmt_write_data},
          {m_busy && !m_wr, m_busy && m_wr, m_busy && m_t1,
           m_busy ? m_addr : 10'h0, m_busy ? m_be : 4'h0, m_busy ? m_wdata : 32'h0});
      chk("rsp_valid", rsp_valid, (m_after == 1) ? 4'(1 << m_who) : 4'b0);
      if (m_after == 1) chk("rsp_payload", {rsp_timeout, rsp_rdata}, {m_to, m_rdata});
    end
    if (!user_reset_n) cur_len = 0;
    else if (cfg_mgmt_read || cfg_mgmt_write) begin
      cur_len++;
      cap_wr = cfg_mgmt_write; cap_addr = cfg_mgmt_addr;
      cap_wdata = cfg_mgmt_write_data; cap_be = cfg_mgmt_byte_enable;
    end
    if (rsp_valid != 0) begin
      rsp_who_q.push_back(rsp_valid); rsp_data_q.push_back(rsp_rdata);
      rsp_to_q.push_back(rsp_timeout); rsp_len_q.push_back(cur_len);
      cur_len = 0;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic clear_log();
    rsp_who_q.delete(); rsp_data_q.delete(); rsp_to_q.delete(); rsp_len_q.delete();
  endtask

  task automatic set_req(input int i, input bit wr, input logic [9:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    req_write[i] = wr; req_type1[i] = 1'b0;
    req_addr[i*10 +: 10] = a; req_wdata[i*32 +: 32] = d; req_be[i*4 +: 4] = be;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_rsp(input string name, input int budget, output bit ok,
                          output logic [3:0] who, output logic [31:0] data,
                          output logic to, output int len);
    ok = 0; who = '0; data = '0; to = 0; len = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge user_clk); #1;
      if (rsp_who_q.size() != 0) ok = 1;
    end
    if (!ok) chk({name, "_no_response"}, 64'(rsp_who_q.size()), 64'd1);
    else begin
      who = rsp_who_q.pop_front(); data = rsp_data_q.pop_front();
      to = rsp_to_q.pop_front(); len = rsp_len_q.pop_front();
    end
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    user_reset_n = 0; req_valid = '0;
    repeat (3) @(negedge user_clk);
    user_reset_n = 1;
  endtask

  logic [3:0] exp_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [3:0] who;
    logic [31:0] data;
    logic to;
    int len;
    bit seen;

    // reset state
    repeat (3) @(negedge user_clk);
    chk("reset_outputs",
        {cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_type1_cfg_reg_access, cfg_mgmt_addr,
         cfg_mgmt_byte_enable, rsp_valid, rsp_timeout, (rsp_rdata | cfg_mgmt_write_data)}, 64'h0);
    user_reset_n = 1;

    // single read from requester 0
    clear_log(); dir_lat = 3; dir_rdata = 32'h1234_5678;
    set_req(0, 0, 10'h004, 32'h0, 4'h0);
    wait_rsp("single_read", 20, ok, who, data, to, len);
    req_valid = '0;
    chk("single_read_who", who, 4'b0001);
    chk("single_read_data", data, 32'h1234_5678);
    chk("single_read_to", to, 1'b0);
    chk("single_read_strobe_len", 64'(len), 64'd3);

    // all four valid after reset: round-robin order
    do_reset(); clear_log(); dir_lat = 2; dir_rdata = 32'h0000_00AA;
    for (int i = 0; i < N; i++) set_req(i, 0, 10'(i), 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("rr_order", 20, ok, who, data, to, len);
      chk($sformatf("rr_order_%0d", i), who, exp_seq[i]);
    end
    req_valid = '0;
    repeat (3) @(negedge user_clk);

    // write from requester 2
    clear_log(); dir_lat = 2; dir_rdata = 32'hDEAD_BEEF;
    set_req(2, 1, 10'h001, 32'h0000_0007, 4'hF);
    wait_rsp("write", 20, ok, who, data, to, len);
    req_valid = '0;
    chk("write_who", who, 4'b0100);
    chk("write_rdata", data, 32'h0);
    chk("write_bus", {cap_wr, cap_addr, cap_be, cap_wdata}, {1'b1, 10'h001, 4'hF, 32'h0000_0007});
    chk("write_be_after_done", cfg_mgmt_byte_enable, 4'h0);
    repeat (3) @(negedge user_clk);

    // watchdog abort, then a normal access
    clear_log(); dir_lat = -1;
    set_req(1, 0, 10'h005, 32'h0, 4'h0);
    wait_rsp("timeout", 40, ok, who, data, to, len);
    req_valid = '0;
    chk("timeout_flag", to, 1'b1);
    chk("timeout_rdata", data, 32'hFFFF_FFFF);
    chk("timeout_strobe_len", 64'(len), 64'd16);
    dir_lat = 2; dir_rdata = 32'hABCD_0001;
    set_req(1, 0, 10'h006, 32'h0, 4'h0);
    wait_rsp("after_timeout", 20, ok, who, data, to, len);
    req_valid = '0;
    chk("after_timeout_flag", to, 1'b0);
    chk("after_timeout_rdata", data, 32'hABCD_0001);
    repeat (3) @(negedge user_clk);

    // reset in the middle of an access
    clear_log(); dir_lat = -1;
    set_req(3, 0, 10'h010, 32'h0, 4'h0);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge user_clk);
      seen = cfg_mgmt_read;
    end
    chk("rst_mid_strobe_seen", seen, 1'b1);
    user_reset_n = 0;
    @(negedge user_clk); #1;
    chk("rst_mid_outputs",
        {cfg_mgmt_read, cfg_mgmt_write, cfg_mgmt_addr, cfg_mgmt_byte_enable, rsp_valid}, 64'h0);
    repeat (2) @(negedge user_clk);
    chk("rst_mid_no_rsp", 64'(rsp_who_q.size()), 64'd0);
    dir_lat = 1; dir_rdata = 32'h5555_0000;
    set_req(0, 0, 10'h011, 32'h0, 4'h0);
    user_reset_n = 1;
    wait_rsp("rst_first", 20, ok, who, data, to, len);
    req_valid[0] = 1'b0;
    chk("rst_first_grant", who, 4'b0001);
    wait_rsp("rst_second", 20, ok, who, data, to, len);
    req_valid = '0;
    chk("rst_second_grant", who, 4'b1000);
    repeat (3) @(negedge user_clk);

    // done coincident with watchdog expiry
    clear_log(); dir_lat = TO; dir_rdata = 32'hCAFE_F00D;
    set_req(2, 0, 10'h020, 32'h0, 4'h0);
    wait_rsp("coincident", 40, ok, who, data, to, len);
    req_valid = '0;
    chk("coincident_to", to, 1'b0);
    chk("coincident_data", data, 32'hCAFE_F00D);
    chk("coincident_len", 64'(len), 64'd16);
    repeat (3) @(negedge user_clk);

    // randomized traffic against the model
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge user_clk); #2;
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (rsp_valid[i] || $urandom_range(0, 49) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_write[i] = 1'($urandom); req_type1[i] = 1'($urandom);
          req_addr[i*10 +: 10] = 10'($urandom); req_wdata[i*32 +: 32] = $urandom;
          req_be[i*4 +: 4] = 4'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    @(negedge user_clk);
    rand_mode = 0; dir_lat = 2; req_valid = '0;
    repeat (40) @(negedge user_clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
